// File: rtl/snake_body.sv
// snake_body: snake head/body movement, growth and collision engine with cell query; define SNAKE_WRAP_EN for wrapping walls
module snake_body #(
  parameter int X_BITS = 6,
  parameter int Y_BITS = 5,
  parameter int GRID_W = 40,
  parameter int GRID_H = 30,
  parameter int MAX_LEN = 16,
  parameter int INIT_LEN = 3,
  parameter int START_X = 20,
  parameter int START_Y = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic [2:0]                   direction,
  input  logic [1:0]                   game_state,
  input  logic [X_BITS-1:0]            food_x,
  input  logic [Y_BITS-1:0]            food_y,
  input  logic [X_BITS-1:0]            query_x,
  input  logic [Y_BITS-1:0]            query_y,
  output logic [X_BITS-1:0]            head_x,
  output logic [Y_BITS-1:0]            head_y,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic                         ate,
  output logic                         collision,
  output logic                         dead,
  output logic                         hit_head,
  output logic                         hit_body
);
  localparam int LW = $clog2(MAX_LEN+1);
  logic [X_BITS-1:0] r_sx [MAX_LEN];
  logic [Y_BITS-1:0] r_sy [MAX_LEN];
  logic [LW-1:0] r_len;
  logic r_ate, r_col, r_dead, r_hh, r_hb;
  logic w_up, w_down, w_left, w_right, w_move, w_food, w_grow, w_self, w_wall, w_fatal;
  logic w_wx, w_wy, w_qh, w_qb;
  logic [X_BITS:0] w_nx_e;
  logic [Y_BITS:0] w_ny_e;
  logic [X_BITS-1:0] w_nx;
  logic [Y_BITS-1:0] w_ny;
  logic [LW-1:0] w_lim;
  assign w_up = direction == 3'd1;
  assign w_down = direction == 3'd2;
  assign w_left = direction == 3'd3;
  assign w_right = direction == 3'd4;
  assign w_move = tick && (w_up || w_down || w_left || w_right) && !r_dead && game_state != 2'b11;
  // one extra bit so that 0-1 lands far above the grid and reads as a wall hit
  assign w_nx_e = w_right ? {1'b0, r_sx[0]} + (X_BITS+1)'(1) : w_left ? {1'b0, r_sx[0]} - (X_BITS+1)'(1) : {1'b0, r_sx[0]};
  assign w_ny_e = w_down ? {1'b0, r_sy[0]} + (Y_BITS+1)'(1) : w_up ? {1'b0, r_sy[0]} - (Y_BITS+1)'(1) : {1'b0, r_sy[0]};
  assign w_wx = w_nx_e >= (X_BITS+1)'(GRID_W);
  assign w_wy = w_ny_e >= (Y_BITS+1)'(GRID_H);
`ifdef SNAKE_WRAP_EN
  assign w_nx = w_wx ? (w_left ? X_BITS'(GRID_W-1) : '0) : w_nx_e[X_BITS-1:0];
  assign w_ny = w_wy ? (w_up ? Y_BITS'(GRID_H-1) : '0) : w_ny_e[Y_BITS-1:0];
  assign w_wall = 1'b0;
`else
  assign w_nx = w_nx_e[X_BITS-1:0];
  assign w_ny = w_ny_e[Y_BITS-1:0];
  assign w_wall = w_wx || w_wy;
`endif
  assign w_food = w_nx == food_x && w_ny == food_y;
  assign w_grow = w_food && r_len < LW'(MAX_LEN);
  // the tail cell is free to enter unless growth keeps it in place
  assign w_lim = w_grow ? r_len : r_len - LW'(1);
  assign w_fatal = w_wall || w_self;
  assign w_qh = query_x == r_sx[0] && query_y == r_sy[0];
  always_comb begin
    w_self = 1'b0;
    w_qb = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_self = w_self | (LW'(i) < w_lim && r_sx[i] == w_nx && r_sy[i] == w_ny);
      w_qb = w_qb | (i > 0 && LW'(i) < r_len && r_sx[i] == query_x && r_sy[i] == query_y);
    end
  end
  always_ff @(posedge clk) begin
    if (reset || game_state == 2'b00) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_sx[i] <= (i < INIT_LEN) ? X_BITS'(START_X - i) : '0;
        r_sy[i] <= (i < INIT_LEN) ? Y_BITS'(START_Y) : '0;
      end
      r_len <= LW'(INIT_LEN);
      r_ate <= 1'b0;
      r_col <= 1'b0;
      r_dead <= 1'b0;
      r_hh <= 1'b0;
      r_hb <= 1'b0;
    end else begin
      r_ate <= 1'b0;
      r_col <= 1'b0;
      r_hh <= w_qh;
      r_hb <= w_qb;
      if (w_move && w_fatal) begin
        r_col <= 1'b1;
        r_dead <= 1'b1;
      end else if (w_move) begin
        for (int i = 1; i < MAX_LEN; i++) begin
          r_sx[i] <= r_sx[i-1];
          r_sy[i] <= r_sy[i-1];
        end
        r_sx[0] <= w_nx;
        r_sy[0] <= w_ny;
        r_len <= r_len + LW'(w_grow);
        r_ate <= w_food;
      end
    end
  end
  assign head_x = r_sx[0];
  assign head_y = r_sy[0];
  assign length = r_len;
  assign ate = r_ate;
  assign collision = r_col;
  assign dead = r_dead;
  assign hit_head = r_hh;
  assign hit_body = r_hb;
endmodule

// File: tb/tb_snake_body.sv
// tb_snake_body: directed checks of snake_body movement, growth, collisions and cell query
module tb_snake_body;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic [2:0] direction = 3'd0;
  logic [1:0] game_state = 2'b01;
  logic [5:0] food_x = '0, query_x = '0, head_x;
  logic [4:0] food_y = '0, query_y = '0, head_y;
  logic [4:0] length;
  logic ate, collision, dead, hit_head, hit_body;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  snake_body dut (
    .clk(clk), .reset(reset), .tick(tick), .direction(direction), .game_state(game_state),
    .food_x(food_x), .food_y(food_y), .query_x(query_x), .query_y(query_y),
    .head_x(head_x), .head_y(head_y), .length(length), .ate(ate), .collision(collision),
    .dead(dead), .hit_head(hit_head), .hit_body(hit_body)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic mv(input logic [2:0] d);
    tick = 1'b1;
    direction = d;
    cyc();
    tick = 1'b0;
    direction = 3'd0;
  endtask
  task automatic restart();
    game_state = 2'b00;
    cyc();
    game_state = 2'b01;
  endtask
  task automatic food(input int x, input int y);
    food_x = 6'(x);
    food_y = 5'(y);
  endtask
  task automatic q(input string tag, input int x, input int y, input int hh, input int hb);
    query_x = 6'(x);
    query_y = 5'(y);
    cyc();
    chk({tag, "_head"}, int'(hit_head), hh);
    chk({tag, "_body"}, int'(hit_body), hb);
  endtask
  task automatic head(input string tag, input int x, input int y);
    chk({tag, "_x"}, int'(head_x), x);
    chk({tag, "_y"}, int'(head_y), y);
  endtask
  initial begin
    cyc();
    cyc();
    reset = 1'b0;
    head("rst_head", 20, 15);
    chk("rst_len", int'(length), 3);
    chk("rst_dead", int'(dead), 0);
    chk("rst_hh", int'(hit_head), 0);
    chk("rst_hb", int'(hit_body), 0);
    q("q18", 18, 15, 0, 1);
    q("q20", 20, 15, 1, 0);
    q("q17", 17, 15, 0, 0);
    for (int k = 0; k < 3; k++) begin
      mv(3'd4);
      chk($sformatf("walk_ate%0d", k), int'(ate), 0);
    end
    head("walk_head", 23, 15);
    chk("walk_len", int'(length), 3);
    q("walk_q21", 21, 15, 0, 1);
    q("walk_q20", 20, 15, 0, 0);
    mv(3'd0);
    mv(3'd5);
    game_state = 2'b11;
    mv(3'd4);
    game_state = 2'b01;
    head("ignored", 23, 15);
    restart();
    head("restart1", 20, 15);
    chk("restart1_len", int'(length), 3);
    food(21, 15);
    mv(3'd4);
    chk("eat_ate", int'(ate), 1);
    chk("eat_len", int'(length), 4);
    head("eat_head", 21, 15);
    cyc();
    chk("eat_ate_off", int'(ate), 0);
    q("eat_tail", 18, 15, 0, 1);
    q("eat_past", 17, 15, 0, 0);
    food(0, 0);
    query_x = 6'd21;
    query_y = 5'd15;
    mv(3'd4);
    chk("preupd_hh", int'(hit_head), 1);
    chk("preupd_hb", int'(hit_body), 0);
    cyc();
    chk("postupd_hh", int'(hit_head), 0);
    chk("postupd_hb", int'(hit_body), 1);
    for (int k = 0; k < 17; k++) mv(3'd4);
    head("edge", 39, 15);
    mv(3'd4);
`ifdef SNAKE_WRAP_EN
    chk("wallr_col", int'(collision), 0);
    chk("wallr_dead", int'(dead), 0);
    head("wallr", 0, 15);
`else
    chk("wallr_col", int'(collision), 1);
    chk("wallr_dead", int'(dead), 1);
    head("wallr", 39, 15);
`endif
    cyc();
    chk("wallr_col_off", int'(collision), 0);
    mv(3'd4);
`ifdef SNAKE_WRAP_EN
    head("after_wall", 1, 15);
`else
    head("after_wall", 39, 15);
    chk("after_wall_dead", int'(dead), 1);
`endif
    restart();
    for (int k = 0; k < 15; k++) mv(3'd1);
    head("top", 20, 0);
    mv(3'd1);
`ifdef SNAKE_WRAP_EN
    chk("wallu_col", int'(collision), 0);
    head("wallu", 20, 29);
`else
    chk("wallu_col", int'(collision), 1);
    head("wallu", 20, 0);
`endif
    restart();
    food(21, 15);
    mv(3'd4);
    food(0, 0);
    mv(3'd2);
    mv(3'd3);
    mv(3'd1);
    chk("tail_col", int'(collision), 0);
    chk("tail_dead", int'(dead), 0);
    head("tail", 20, 15);
    restart();
    food(21, 15);
    mv(3'd4);
    food(22, 15);
    mv(3'd4);
    chk("loop_len5", int'(length), 5);
    food(0, 0);
    mv(3'd2);
    mv(3'd3);
    mv(3'd1);
    chk("loop_col", int'(collision), 1);
    chk("loop_dead", int'(dead), 1);
    head("loop", 21, 16);
    chk("loop_len", int'(length), 5);
    restart();
    head("reinit", 20, 15);
    chk("reinit_len", int'(length), 3);
    chk("reinit_dead", int'(dead), 0);
    chk("reinit_col", int'(collision), 0);
    for (int k = 0; k < 13; k++) begin
      food(21 + k, 15);
      mv(3'd4);
      chk($sformatf("grow_ate%0d", k), int'(ate), 1);
    end
    chk("full_len", int'(length), 16);
    head("full", 33, 15);
    food(34, 15);
    mv(3'd4);
    chk("sat_ate", int'(ate), 1);
    chk("sat_len", int'(length), 16);
    head("sat", 34, 15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
